control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 No parameters; the block SHALL be fixed-function.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 needWait  input  1  memory-controller stall request; sampled only in FETCH and MEM.
REQ-005 fetch_en  output  1  enables the fetch stage and its memory read.
REQ-006 decode_en  output  1  enables the decoder stage.
REQ-007 alu_en  output  1  enables the ALU stage.
REQ-008 mem_en  output  1  grants the memory controller to the data-memory stage.
REQ-009 reg_write_en  output  1  enables register/PC writeback.
REQ-010 incr_pc  output  1  one-cycle strobe; the PC advances by 2 at the next edge.
REQ-011 dbg_state  output  10  debug view: [4:0] one-hot state, [5] stall flag, [9:6] retired-instruction count.

Function
REQ-012 The FSM SHALL have five one-hot states, cycled in order FETCH(bit0), DECODE(bit1), ALU(bit2), MEM(bit3), REGWRITE(bit4), then back to FETCH.
REQ-013 Each enable SHALL be a Moore decode of its state:
- fetch_en = FETCH
- decode_en = DECODE
- alu_en = ALU
- mem_en = MEM
- reg_write_en = REGWRITE
- Exactly one enable SHALL be high per cycle out of reset.
REQ-014 In FETCH and MEM, needWait=1 SHALL hold the state and keep its enable high; needWait=0 SHALL advance the state at the next edge.
REQ-015 In DECODE, ALU and REGWRITE, needWait SHALL be ignored; each of these states SHALL last exactly one cycle.
REQ-016 incr_pc SHALL equal FETCH & !needWait, so it pulses exactly once per instruction, in the cycle the fetch completes.
REQ-017 incr_pc SHALL never be high together with reg_write_en, so a PC load in writeback is not overridden.
REQ-018 Latency SHALL be 5 cycles per instruction with no stalls; each needWait cycle in FETCH or MEM SHALL add one cycle.
REQ-019 dbg_state[5] SHALL equal needWait & (FETCH | MEM), combinationally.
REQ-020 dbg_state[9:6] SHALL increment by 1 on each REGWRITE->FETCH transition and wrap from 15 to 0.

Reset
REQ-021 While rst_n=0, the FSM SHALL asynchronously enter FETCH and the count SHALL clear to 0.
REQ-022 While rst_n=0, all enables and incr_pc SHALL be forced to 0 and dbg_state SHALL read 10'h001.
REQ-023 On the first rising edge of clk after rst_n goes high, the FSM SHALL be in FETCH with fetch_en=1.
REQ-024 Reset asserted in any state, mid-stall included, SHALL abort the current instruction without producing any incr_pc or reg_write_en pulse.

Verification
REQ-025 Release reset with needWait=0 -> dbg_state SHALL read 001, 002, 004, 008, 010, 041; incr_pc SHALL be high only in the FETCH cycle.
REQ-026 needWait=1 for 3 cycles in FETCH -> fetch_en SHALL be high 4 cycles, dbg_state SHALL read 021 during the stall, and incr_pc SHALL pulse only in the 4th cycle.
REQ-027 needWait=1 for 2 cycles in MEM -> mem_en SHALL be high 3 cycles, dbg_state SHALL read 028 during the stall, then REGWRITE SHALL follow.
REQ-028 needWait=1 throughout DECODE and ALU -> each state SHALL still last exactly 1 cycle and dbg_state[5] SHALL stay 0.
REQ-029 Run 16 unstalled instructions -> dbg_state[9:6] SHALL wrap to 0 and dbg_state SHALL read 001 in the next FETCH.
REQ-030 Assert rst_n=0 during ALU -> outputs SHALL be 0 immediately, and after release the bench SHALL see FETCH with count 0.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: five-stage multicycle sequencer (FETCH, DECODE, ALU, MEM, REGWRITE) with memory stall support
//   clk          : single clock, rising edge
//   rst_n        : asynchronous active-low reset
//   needWait     : memory stall request, honoured only in FETCH and MEM
//   fetch_en     : fetch stage / instruction read enable
//   decode_en    : decoder enable
//   alu_en       : ALU enable
//   mem_en       : memory controller granted to data stage
//   reg_write_en : register/PC writeback enable
//   incr_pc      : PC += 2 strobe, high in the cycle a fetch completes
//   dbg_state    : {retired count[3:0], stall, one-hot state[4:0]}
module control_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       needWait,
  output logic       fetch_en,
  output logic       decode_en,
  output logic       alu_en,
  output logic       mem_en,
  output logic       reg_write_en,
  output logic       incr_pc,
  output logic [9:0] dbg_state
);
  typedef enum logic [4:0] {
    FETCH    = 5'b00001,
    DECODE   = 5'b00010,
    ALU      = 5'b00100,
    MEM      = 5'b01000,
    REGWRITE = 5'b10000
  } state_t;
  state_t     state, state_nx;
  logic [3:0] count;
  logic       stall;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= FETCH;
      count <= 4'd0;
    end else begin
      state <= state_nx;
      if (state == REGWRITE) count <= count + 4'd1;
    end
  // Only FETCH and MEM talk to the memory controller, so only they can stall.
  assign stall = rst_n & needWait & ((state == FETCH) | (state == MEM));
  always_comb begin
    state_nx = state;
    if (!stall)
      state_nx = state == FETCH  ? DECODE :
                 state == DECODE ? ALU :
                 state == ALU    ? MEM :
                 state == MEM    ? REGWRITE : FETCH;
  end
  // Outputs are gated by rst_n directly so an aborted instruction emits nothing while reset is held.
  assign fetch_en     = rst_n & (state == FETCH);
  assign decode_en    = rst_n & (state == DECODE);
  assign alu_en       = rst_n & (state == ALU);
  assign mem_en       = rst_n & (state == MEM);
  assign reg_write_en = rst_n & (state == REGWRITE);
  assign incr_pc      = fetch_en & ~needWait;
  assign dbg_state    = rst_n ? {count, stall, state} : 10'h001;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed self-checking bench for control_unit
module tb_control_unit;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       need_wait = 1'b0;
  logic       fetch_en, decode_en, alu_en, mem_en, reg_write_en, incr_pc;
  logic [9:0] dbg_state;
  int checks = 0;
  int errors = 0;
  control_unit dut (
    .clk(clk), .rst_n(rst_n), .needWait(need_wait),
    .fetch_en(fetch_en), .decode_en(decode_en), .alu_en(alu_en),
    .mem_en(mem_en), .reg_write_en(reg_write_en), .incr_pc(incr_pc),
    .dbg_state(dbg_state)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic look(input string tag, input logic [9:0] edbg, input logic [5:0] een);
    check({tag, "_dbg"}, {22'd0, dbg_state}, {22'd0, edbg});
    check({tag, "_en"}, {26'd0, incr_pc, reg_write_en, mem_en, alu_en, decode_en, fetch_en}, {26'd0, een});
  endtask
  task automatic cyc(input string tag, input logic nw, input logic [9:0] edbg, input logic [5:0] een);
    @(negedge clk);
    need_wait = nw;
    #1;
    look(tag, edbg, een);
  endtask
  // en vector order: {incr_pc, reg_write_en, mem_en, alu_en, decode_en, fetch_en}
  initial begin
    repeat (2) @(negedge clk);
    #1 look("rst", 10'h001, 6'b000000);
    need_wait = 1'b1;
    #1 look("rst_nw", 10'h001, 6'b000000);
    @(negedge clk);
    rst_n = 1'b1;
    need_wait = 1'b0;
    #1 look("rel_fetch", 10'h001, 6'b100001);
    cyc("dec0", 1'b0, 10'h002, 6'b000010);
    cyc("alu0", 1'b0, 10'h004, 6'b000100);
    cyc("mem0", 1'b0, 10'h008, 6'b001000);
    cyc("wb0", 1'b0, 10'h010, 6'b010000);
    cyc("fst1", 1'b1, 10'h061, 6'b000001);
    cyc("fst2", 1'b1, 10'h061, 6'b000001);
    cyc("fst3", 1'b1, 10'h061, 6'b000001);
    cyc("fgo", 1'b0, 10'h041, 6'b100001);
    cyc("dec1", 1'b0, 10'h042, 6'b000010);
    cyc("alu1", 1'b0, 10'h044, 6'b000100);
    cyc("mst1", 1'b1, 10'h068, 6'b001000);
    cyc("mst2", 1'b1, 10'h068, 6'b001000);
    cyc("mgo", 1'b0, 10'h048, 6'b001000);
    cyc("wb1", 1'b0, 10'h050, 6'b010000);
    cyc("fetch2", 1'b0, 10'h081, 6'b100001);
    cyc("dec_nw", 1'b1, 10'h082, 6'b000010);
    cyc("alu_nw", 1'b1, 10'h084, 6'b000100);
    cyc("mem2", 1'b0, 10'h088, 6'b001000);
    cyc("wb_nw", 1'b1, 10'h090, 6'b010000);
    for (int i = 3; i < 16; i++)
      for (int k = 0; k < 5; k++) begin
        logic [3:0] c;
        logic [4:0] oh;
        c = 4'(i);
        oh = 5'(1 << k);
        cyc("run", 1'b0, {c, 1'b0, oh}, k == 0 ? 6'b100001 : 6'(1 << k));
      end
    cyc("wrap", 1'b0, 10'h001, 6'b100001);
    cyc("dec_r", 1'b0, 10'h002, 6'b000010);
    cyc("alu_r", 1'b0, 10'h004, 6'b000100);
    rst_n = 1'b0;
    #1 look("rst_alu", 10'h001, 6'b000000);
    @(negedge clk);
    rst_n = 1'b1;
    #1 look("rel2", 10'h001, 6'b100001);
    cyc("dec_s", 1'b0, 10'h002, 6'b000010);
    cyc("alu_s", 1'b0, 10'h004, 6'b000100);
    cyc("mst_s", 1'b1, 10'h028, 6'b001000);
    rst_n = 1'b0;
    #1 look("rst_mst", 10'h001, 6'b000000);
    @(posedge clk);
    #1 look("rst_hold", 10'h001, 6'b000000);
    @(negedge clk);
    rst_n = 1'b1;
    need_wait = 1'b0;
    #1 look("rel3", 10'h001, 6'b100001);
    cyc("dec_t", 1'b0, 10'h002, 6'b000010);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
